// File: rtl/letc_mem_arbiter.sv
// letc_mem_arbiter: round-robin arbiter sharing one memory port, one transaction in flight.
// Define LETC_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES with an error response.
module letc_mem_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ*32-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]    i_req_wen,
    input  logic [NUM_REQ*4-1:0]  i_req_wstrb,
    input  logic [NUM_REQ*32-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [31:0]           o_mem_addr,
    output logic                  o_mem_wen,
    output logic [3:0]            o_mem_wstrb,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_rsp_valid,
    input  logic [31:0]           i_mem_rsp_rdata,
    input  logic                  i_mem_rsp_err
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("letc_mem_arbiter: unsupported parameters");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_ptr, r_grant, w_win;
    logic          w_any, w_timeout, w_wen;
    logic [31:0]   w_addr, w_wdata;
    logic [3:0]    w_wstrb;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic          r_wen, r_err;
    logic [3:0]    r_wstrb;

    always_comb begin
        w_any   = |i_req_valid;
        w_win   = '0;
        w_addr  = '0;
        w_wen   = 1'b0;
        w_wstrb = '0;
        w_wdata = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (i_req_valid[i]) w_win = IW'(i);
        // any valid requester at or after the pointer beats the wrapped-around lowest one
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (i_req_valid[i] && i >= int'(r_ptr)) w_win = IW'(i);
        for (int i = 0; i < NUM_REQ; i++)
            if (w_win == IW'(i)) begin
                w_addr  = i_req_addr[i*32 +: 32];
                w_wen   = i_req_wen[i];
                w_wstrb = i_req_wstrb[i*4 +: 4];
                w_wdata = i_req_wdata[i*32 +: 32];
            end
    end

`ifdef LETC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    assign w_timeout = r_state == WAIT && !i_mem_rsp_valid && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        if (rst || r_state != WAIT) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = REQ;
            REQ:     if (i_mem_ready) w_next = WAIT;
            WAIT:    if (i_mem_rsp_valid || w_timeout) w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_win;
                r_addr  <= w_addr;
                r_wen   <= w_wen;
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata;
            end
            if (r_state == WAIT && i_mem_rsp_valid) begin
                r_rdata <= i_mem_rsp_rdata;
                r_err   <= i_mem_rsp_err;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
            if (r_state == RESP)
                r_ptr <= (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;
        end
    end

    // accepts are suppressed while rst is high since nothing would be captured
    assign o_req_ready = (r_state == IDLE && !rst && w_any) ? NUM_REQ'(1) << w_win : '0;
    assign o_rsp_valid = (r_state == RESP) ? NUM_REQ'(1) << r_grant : '0;
    assign o_rsp_rdata = (r_state == RESP) ? r_rdata : '0;
    assign o_rsp_err   = (r_state == RESP) && r_err;
    assign o_mem_valid = r_state == REQ;
    assign o_mem_addr  = r_addr;
    assign o_mem_wen   = r_wen;
    assign o_mem_wstrb = r_wstrb;
    assign o_mem_wdata = r_wdata;
endmodule
